btn_conditioner: RTL
====================

# btn_conditioner

- Input-side counterpart to the seven-segment display path: turns raw, bouncing push-button levels into clean, clock-synchronous events for the datapath.
- Per channel, it synchronises the raw button, debounces it, and emits one-cycle press and release pulses.
- While a button stays held, it also emits auto-repeat pulses.
- Sits between the board buttons (BTN1..3, inverted BTN_N) and any register that is loaded "on button", replacing edge-triggering directly on button nets.

## Interface
Parameters:
- N_BTN, 4, number of independent button channels
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz); legal range ≥ 2
- HOLD_CYCLES, 6000000, cycles from press acceptance to first repeat pulse; legal range ≥ 2
- REPEAT_CYCLES, 1200000, cycles between subsequent repeat pulses; legal range ≥ 1

Ports:
- CLK, in, 1, system clock; all logic on its rising edge
- RST_N, in, 1, asynchronous active-low reset
- btn_raw, in, N_BTN, asynchronous button levels, active-high (the instantiating level inverts active-low buttons)
- btn_level, out, N_BTN, debounced level per channel
- press_pulse, out, N_BTN, one-cycle pulse when a press is accepted
- release_pulse, out, N_BTN, one-cycle pulse when a release is accepted
- repeat_pulse, out, N_BTN, one-cycle auto-repeat pulse while held

## Operation
- **Channels.** Channels are fully independent. Several channels may pulse in the same cycle.
- **Synchroniser.** btn_raw[i] passes through a 2-flop synchroniser; its output is `s[i]`. Both flops reset to 0.
- **FSM states per channel:** RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
- **Debounce counter.** One per channel, width $clog2(DEBOUNCE_CYCLES+1).
  - Cleared on every state entry.
  - Increments each cycle in a PEND state while `s` holds the pending value.
- **RELEASED:**
  - `s`=1 → PRESS_PEND.
  - Otherwise stay.
- **PRESS_PEND:**
  - `s`=0 → back to RELEASED. No pulse; the glitch is discarded.
  - Count reaches DEBOUNCE_CYCLES → PRESSED, with btn_level←1 and press_pulse=1 for one cycle.
- **PRESSED:**
  - `s`=0 → RELEASE_PEND.
  - The hold counter runs only in this state (width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)).
  - First repeat_pulse comes HOLD_CYCLES cycles after the press_pulse cycle.
  - Further repeat_pulses follow every REPEAT_CYCLES cycles.
  - The counter reloads after each pulse and never wraps silently.
- **RELEASE_PEND:**
  - `s`=1 → back to PRESSED.
  - Count reaches DEBOUNCE_CYCLES → RELEASED, with btn_level←0 and release_pulse=1 for one cycle.
- **Hold counter across a bounce.** The hold counter does not count in RELEASE_PEND. On return to PRESSED it resumes from its held value; bounce during a hold does not restart the repeat schedule.
- **Output exclusivity.** press_pulse, release_pulse and repeat_pulse are mutually exclusive per channel in any cycle.
- **Registered outputs.** All outputs come from registers; there is no combinational path from btn_raw.

## Timing
- **Reset:**
  - RST_N low asynchronously forces every output to 0, all FSMs to RELEASED, and synchronisers and counters to 0.
  - Reset asserted mid-operation drops any pending or held state with no release_pulse.
  - A button held through reset deassertion is reported as a fresh press, DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- **Press latency.** btn_raw rising and then stable → press_pulse high in the cycle after edge DEBOUNCE_CYCLES+2, counted from the first edge that samples btn_raw high. btn_level rises on the same edge.
- **Release latency.** Symmetric: DEBOUNCE_CYCLES+2 edges.
- **Glitch rejection:**
  - A raw pulse seen by `s` for fewer than DEBOUNCE_CYCLES consecutive cycles produces no event.
  - A pulse of exactly DEBOUNCE_CYCLES cycles produces an event.
- **Pulse width.** Each pulse is exactly 1 cycle wide.
- **Repeat timing.** repeat_pulse k (k ≥ 1) fires HOLD_CYCLES + (k−1)·REPEAT_CYCLES cycles after press_pulse, counting only cycles spent in PRESSED.

## Test plan
Parameters for all cases: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, N_BTN=4.

- **Clean press/release:** btn_raw[0] high at edge 10, held 50 cycles, then low.
  - press_pulse[0] for one cycle after edge 16.
  - btn_level[0]=1 from edge 16.
  - release_pulse[0] one cycle, DEBOUNCE_CYCLES+2 edges after the falling sample.
  - No activity on other channels.
- **Bounce rejection:**
  - btn_raw[1] toggles 1,0,1,0 with 2-cycle high periods, then holds high → exactly one press_pulse[1], 6 edges after the final rise.
  - A 3-cycle high glitch alone → no pulse, btn_level[1] stays 0.
- **Auto-repeat:** hold btn_raw[2] for 60 cycles after acceptance.
  - repeat_pulse[2] at +20, +28, +36, +44, +52 cycles after press_pulse[2].
  - Release → release_pulse[2], then no further repeats.
- **Release bounce during hold:** while held, drop btn_raw[2] for 2 cycles at +10.
  - No release_pulse.
  - Repeat schedule is shifted only by the cycles spent in RELEASE_PEND.
- **Simultaneous channels:** all four btn_raw rise on the same edge → all four press_pulse bits high in the same cycle.
- **Reset mid-hold:** assert RST_N low while btn_raw[3] is held with btn_level[3]=1.
  - All outputs are 0 immediately (asynchronously).
  - After deassertion with the button still held, press_pulse[3] fires 6 edges later.
  - No release_pulse is ever emitted for the interrupted hold.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per channel, synchronise the raw level, debounce it and
// emit one-cycle press, release and auto-repeat pulses. All outputs are registered.
module btn_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned HOLD_CYCLES     = 6000000,
  parameter int unsigned REPEAT_CYCLES   = 1200000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  // The sample that enters a PEND state already counts as one stable cycle, so the
  // transition fires when the counter holds DEBOUNCE_CYCLES-2.
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 2);
  // Hold counter counts down; reaching zero fires a repeat and reloads.
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] RepLoad  = HoldW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressPend,
    StPressed,
    StReleasePend
  } state_e;

  logic [N_BTN-1:0] sync_meta_q;
  logic [N_BTN-1:0] sync_q;

  // Two-flop synchroniser for every raw button level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= btn_raw;
      sync_q      <= sync_meta_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_e           state_q;
    logic [DbW-1:0]   db_cnt_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;

    // Per-channel debounce FSM with registered level and pulse outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q    <= StReleased;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        unique case (state_q)
          StReleased: begin
            if (sync_q[i]) begin
              state_q  <= StPressPend;
              db_cnt_q <= '0;
            end
          end
          StPressPend: begin
            if (!sync_q[i]) begin
              state_q  <= StReleased;
              db_cnt_q <= '0;
            end else if (db_cnt_q == DbLast) begin
              state_q    <= StPressed;
              db_cnt_q   <= '0;
              level_q    <= 1'b1;
              press_q    <= 1'b1;
              hold_cnt_q <= HoldLoad;
            end else begin
              db_cnt_q <= db_cnt_q + DbW'(1);
            end
          end
          StPressed: begin
            // Every cycle spent in this state advances the repeat schedule.
            if (hold_cnt_q == '0) begin
              repeat_q   <= 1'b1;
              hold_cnt_q <= RepLoad;
            end else begin
              hold_cnt_q <= hold_cnt_q - HoldW'(1);
            end
            if (!sync_q[i]) begin
              state_q  <= StReleasePend;
              db_cnt_q <= '0;
            end
          end
          StReleasePend: begin
            // hold_cnt_q is frozen here so a bounce only delays the schedule.
            if (sync_q[i]) begin
              state_q  <= StPressed;
              db_cnt_q <= '0;
            end else if (db_cnt_q == DbLast) begin
              state_q   <= StReleased;
              db_cnt_q  <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              db_cnt_q <= db_cnt_q + DbW'(1);
            end
          end
          default: begin
            state_q  <= StReleased;
            db_cnt_q <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule
